// File: rtl/core_dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, access sizes, STRB size patterns.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package core_dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } resp_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    localparam logic [3:0] STRB_WORD    = 4'b1111;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;

    // Access size is implied by the byte-enable pattern; anything that is not a
    // full word or an aligned half pair is treated as a byte access.
    function automatic acc_size_e strb_to_size(input logic [3:0] strb);
        acc_size_e sz;
        if (strb == STRB_WORD)
            sz = SZ_WORD;
        else if ((strb == STRB_HALF_LO) || (strb == STRB_HALF_HI))
            sz = SZ_HALF;
        else
            sz = SZ_BYTE;
        return sz;
    endfunction

endpackage

// File: rtl/core_dmem_lane.sv
// Byte-lane steering: shifts store data into its lanes and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; reusable by an instruction-memory responder.
module core_dmem_lane
    import core_dmem_responder_pkg::*;
(
    input  logic [1:0]  i_byte_off,
    input  acc_size_e   i_size,
    input  logic        i_sx_byte,
    input  logic        i_sx_half,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata
);

    logic [31:0] w_rshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_wword  = i_wdata << {i_byte_off, 3'b000};
    assign w_rshift = i_rword >> {i_byte_off, 3'b000};
    assign w_byte   = w_rshift[7:0];
    assign w_half   = i_byte_off[1] ? i_rword[31:16] : i_rword[15:0];

    // Select the addressed lane(s) and apply sign or zero extension.
    always_comb begin
        o_rdata = i_rword;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_sx_byte & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_sx_half & w_half[15]}}, w_half};
            default: o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory responder: single-shot load/store into an internal word RAM with wait states.
// Latency: DONE in cycle WAIT_STATES+2 after the accept cycle, back to IDLE one cycle later.
// Backpressure: none; request pulses outside IDLE are dropped, BUSY lets the hazard unit stall.
module core_dmem_responder
    import core_dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_isload_ss,
    input  logic        i_isstore_ss,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_wdata,
    input  logic        i_isloadbs,
    input  logic        i_isloadhws,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    resp_state_e r_state;
    resp_state_e w_state_nx;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nx;
    logic        w_accept;

    // Request captured at acceptance
    logic          r_load;
    logic          r_rej;
    logic [1:0]    r_off;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;
    logic          r_sx_b;
    logic          r_sx_h;
    acc_size_e     r_size;

    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    acc_size_e   w_size;
    logic [31:0] w_rel;
    logic        w_in_range;
    logic        w_misalign;
    logic        w_rej;
    logic        w_unused_rel;
    logic [31:0] w_rword;
    logic [31:0] w_wword;
    logic [31:0] w_lane_rdata;
    logic [31:0] w_merged;

    // Request validation happens on the raw inputs so the verdict is frozen at acceptance.
    assign w_size       = strb_to_size(i_strb);
    assign w_rel        = i_addr - BASE_ADDR;
    assign w_in_range   = (i_addr >= BASE_ADDR) && ({1'b0, w_rel} < SPAN);
    assign w_misalign   = ((w_size == SZ_HALF) && i_addr[0]) ||
                          ((w_size == SZ_WORD) && (i_addr[1:0] != 2'b00));
    assign w_rej        = (i_isload_ss & i_isstore_ss) | ~w_in_range | w_misalign |
                          (i_strb == 4'b0000);
    // Bits of the relative address that do not form the word index.
    assign w_unused_rel = ^{w_rel[31:AW+2], w_rel[1:0]};

    assign w_rword = r_mem[r_idx];

    core_dmem_lane u_lane (
        .i_byte_off (r_off),
        .i_size     (r_size),
        .i_sx_byte  (r_sx_b),
        .i_sx_half  (r_sx_h),
        .i_wdata    (r_wdata),
        .i_rword    (w_rword),
        .o_wword    (w_wword),
        .o_rdata    (w_lane_rdata)
    );

    // Merge shifted store data into the current word under the byte enables.
    always_comb begin
        w_merged = w_rword;
        for (int b = 0; b < 4; b++) begin
            if (r_strb[b])
                w_merged[8*b +: 8] = w_wword[8*b +: 8];
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_isload_ss | i_isstore_ss) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nx = ST_ACCESS;
                    end else begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0)
                    w_state_nx = ST_ACCESS;
                else
                    w_cnt_nx = r_cnt - 4'd1;
            end
            ST_ACCESS: w_state_nx = ST_RESP;
            ST_RESP:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // State and wait counter registers; reset aborts any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Capture the request and its accept/reject verdict in the accept cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_load  <= 1'b0;
            r_rej   <= 1'b0;
            r_off   <= 2'b00;
            r_idx   <= '0;
            r_strb  <= 4'b0000;
            r_wdata <= 32'd0;
            r_sx_b  <= 1'b0;
            r_sx_h  <= 1'b0;
            r_size  <= SZ_BYTE;
        end else if (w_accept) begin
            r_load  <= i_isload_ss;
            r_rej   <= w_rej;
            r_off   <= i_addr[1:0];
            r_idx   <= w_rel[AW+1:2];
            r_strb  <= i_strb;
            r_wdata <= i_wdata;
            r_sx_b  <= i_isloadbs;
            r_sx_h  <= i_isloadhws;
            r_size  <= w_size;
        end
    end

    // Single-port RAM write in ACCESS for accepted stores; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == ST_ACCESS) && !r_rej && !r_load)
            r_mem[r_idx] <= w_merged;
    end

    // Load result registered on entry to RESP; cleared by a rejection, kept by stores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= 32'd0;
        end else if (r_state == ST_ACCESS) begin
            if (r_rej)
                r_rdata <= 32'd0;
            else if (r_load)
                r_rdata <= w_lane_rdata;
        end
    end

    assign o_rdata = r_rdata;
    assign o_busy  = (r_state == ST_WAIT) || (r_state == ST_ACCESS);
    assign o_done  = (r_state == ST_RESP);
    assign o_err   = (r_state == ST_RESP) && r_rej;

endmodule
